host_frame_tx: RTL and testbench
================================

HOST_FRAME_TX -- requirements
Module: host_frame_tx

Interface
REQ-001: Parameter DATA_WIDTH, default 8, is the width of one serial data byte and of each argument.
REQ-002: CLK  input  1  is the single clock; all state updates on the rising edge.
REQ-003: RST  input  1  is the reset: asynchronous assertion, active-low, with synchronous release supplied externally.
REQ-004: CMD_VALID  input  1  is the command request, qualified by CMD_READY.
REQ-005: CMD_READY  output  1  is high when a command can be accepted.
REQ-006: CMD_TYPE  input  2  selects the command: 0=RF write (0xAA), 1=RF read (0xBB), 2=ALU with operands (0xCC), 3=ALU no operands (0xDD).
REQ-007: ARG0, ARG1, ARG2  input  DATA_WIDTH each  are the command arguments.
REQ-008: BAUD_DIV  input  16  gives the CLK cycles per serial bit.
REQ-009: PAR_EN  input  1  enables parity; PAR_TYP  input  1  selects the parity type (0=even, 1=odd).
REQ-010: TX_OUT  output  1  is the serial line that drives the system RX_IN; it idles high.
REQ-011: BUSY  output  1  is high from command accept until the last stop bit (or gap) completes.
REQ-012: DONE  output  1  is a one-cycle pulse at command completion.

Function
REQ-013: A command SHALL be accepted on any rising edge where CMD_VALID=1 and CMD_READY=1; the block captures CMD_TYPE, ARG0-2, BAUD_DIV, PAR_EN and PAR_TYP, and later changes to these inputs are ignored.
REQ-014: Byte sequence per command type:
- AA: AA, ARG0 (addr), ARG1 (data).
- BB: BB, ARG0 (addr).
- CC: CC, ARG0 (A), ARG1 (B), ARG2 (func).
- DD: DD, ARG0 (func).
REQ-015: The state machine SHALL have the states IDLE, START, DATA, PARITY, STOP and GAP; transitions are:
- IDLE->START on accept.
- START->DATA.
- DATA->PARITY after DATA_WIDTH bits when parity is enabled, otherwise DATA->STOP.
- PARITY->STOP.
- STOP->START when more bytes remain (through GAP when the gap is compiled in).
- STOP->IDLE after the last byte.
REQ-016: Each bit SHALL last exactly max(BAUD_DIV,1) CLK cycles; BAUD_DIV=0 behaves as 1.
REQ-017: TX_OUT SHALL be 0 in START, the data bits LSB first in DATA, the parity bit in PARITY, 1 in STOP/GAP/IDLE.
REQ-018: The parity bit SHALL be the XOR of the data bits for even parity and the inverted XOR for odd parity.
REQ-019: The start bit SHALL appear on TX_OUT in the cycle after the accept edge.
REQ-020: CMD_READY SHALL equal (state==IDLE); CMD_VALID while BUSY is ignored and never queued.
REQ-021: DONE and CMD_READY SHALL both be high in the first IDLE cycle after the final stop bit; a command accepted in that cycle starts normally.
REQ-022: The byte counter SHALL stop at the per-type byte count and SHALL never wrap into an extra frame.

Reset
REQ-023: While RST=0: state=IDLE, TX_OUT=1, CMD_READY=1, BUSY=0, DONE=0, all counters and captured registers =0.
REQ-024: Reset asserted mid-frame SHALL force TX_OUT=1 immediately (asynchronously) and abandon the command with no DONE.

Configuration
REQ-025: Macro HOST_FRAME_TX_GAP_EN defined: after every non-final stop bit the block holds GAP (TX_OUT=1) for one bit period before the next START.
REQ-026: Macro HOST_FRAME_TX_GAP_EN undefined: frames are back-to-back and the GAP state is absent.

Verification
REQ-027: BAUD_DIV=4, PAR_EN=0, AA with ARG0=0x05, ARG1=0x3C -> frames AA,05,3C; each 40 cycles; BUSY=1 for 120 cycles; DONE one cycle later (gap macro off).
REQ-028: BB with ARG0=0x0A, PAR_EN=1 -> parity bit 0 on the AA-free BB frame for even; repeated with odd -> 1; frame length 11 bits.
REQ-029: CC with ARG0=0x10, ARG1=0x20, ARG2=0x01, BAUD_DIV=0 -> 4 frames at 1 cycle/bit, 40 cycles total.
REQ-030: CMD_VALID held high through a DD command -> exactly one command sent; second command starts in the DONE cycle.
REQ-031: RST low during the DATA bit 3 of byte 2 -> TX_OUT=1 at once, no DONE; a fresh command after release sends correct frames.
REQ-032: HOST_FRAME_TX_GAP_EN defined, DD with BAUD_DIV=2 -> 2 frames separated by 2 idle-high cycles, BUSY=42 cycles.

Source files
------------

// File: rtl/host_frame_tx.sv
// -----------------------------------------------------------------------------
// host_frame_tx
//   Serialises one host command (header byte plus its arguments) onto a UART
//   style line: start bit, DATA_WIDTH data bits LSB first, optional parity bit,
//   one stop bit.  One command is accepted at a time; everything needed for the
//   command is captured at accept so the host may change its inputs freely.
//
// Ports
//   CLK        in   clock, all state on the rising edge
//   RST        in   asynchronous active-low reset
//   CMD_VALID  in   command request, accepted when CMD_READY is high
//   CMD_READY  out  high while idle
//   CMD_TYPE   in   0=RF write (AA), 1=RF read (BB), 2=ALU op (CC), 3=ALU no-op (DD)
//   ARG0..2    in   command arguments (DATA_WIDTH each)
//   BAUD_DIV   in   CLK cycles per serial bit (0 behaves as 1)
//   PAR_EN     in   parity bit enable
//   PAR_TYP    in   0=even, 1=odd parity
//   TX_OUT     out  serial line, idles high
//   BUSY       out  high from accept until the last stop bit completes
//   DONE       out  one-cycle pulse in the first idle cycle after a command
//
// Build option
//   HOST_FRAME_TX_GAP_EN : when defined, one idle-high bit period (GAP) is
//   inserted after every non-final stop bit.
// -----------------------------------------------------------------------------
module host_frame_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [1:0]            CMD_TYPE,
    input  logic [DATA_WIDTH-1:0] ARG0,
    input  logic [DATA_WIDTH-1:0] ARG1,
    input  logic [DATA_WIDTH-1:0] ARG2,
    input  logic [15:0]           BAUD_DIV,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] HDR_AA = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] HDR_BB = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] HDR_CC = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] HDR_DD = DATA_WIDTH'(8'hDD);

`ifdef HOST_FRAME_TX_GAP_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`endif

    // Parity over one data byte; odd parity is the inverted even result.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic odd);
        calc_parity = (^data) ^ odd;
    endfunction

    // Index of the final byte of each command type.
    function automatic logic [1:0] last_index(input logic [1:0] cmd);
        case (cmd)
            2'd0:    last_index = 2'd2;
            2'd1:    last_index = 2'd1;
            2'd2:    last_index = 2'd3;
            2'd3:    last_index = 2'd1;
            default: last_index = 2'd1;
        endcase
    endfunction

    // Byte to transmit for a given command type and byte position.
    function automatic logic [DATA_WIDTH-1:0] byte_sel(
        input logic [1:0]            cmd,
        input logic [1:0]            idx,
        input logic [DATA_WIDTH-1:0] a0,
        input logic [DATA_WIDTH-1:0] a1,
        input logic [DATA_WIDTH-1:0] a2
    );
        case (idx)
            2'd0: begin
                case (cmd)
                    2'd0:    byte_sel = HDR_AA;
                    2'd1:    byte_sel = HDR_BB;
                    2'd2:    byte_sel = HDR_CC;
                    2'd3:    byte_sel = HDR_DD;
                    default: byte_sel = HDR_AA;
                endcase
            end
            2'd1:    byte_sel = a0;
            2'd2:    byte_sel = a1;
            2'd3:    byte_sel = a2;
            default: byte_sel = a0;
        endcase
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_type;
    logic [DATA_WIDTH-1:0] r_arg0;
    logic [DATA_WIDTH-1:0] r_arg1;
    logic [DATA_WIDTH-1:0] r_arg2;
    logic [15:0]           r_baud;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [15:0]           r_baud_cnt;
    logic [BCW-1:0]        r_bit_cnt;
    logic [1:0]            r_byte_idx;
    logic                  r_tx;
    logic                  r_done;

    logic [15:0]           w_div;
    logic                  w_bit_end;
    logic                  w_last_byte;
    logic [DATA_WIDTH-1:0] w_cur_byte;
    logic                  w_par;
    logic                  w_accept;
    logic                  w_done;
    logic [BCW-1:0]        w_nbit;
    logic                  w_tx;

    assign w_div       = (r_baud == 16'd0) ? 16'd1 : r_baud;
    assign w_bit_end   = (r_baud_cnt == (w_div - 16'd1));
    assign w_last_byte = (r_byte_idx == last_index(r_type));
    assign w_cur_byte  = byte_sel(r_type, r_byte_idx, r_arg0, r_arg1, r_arg2);
    assign w_par       = calc_parity(w_cur_byte, r_par_typ);

    assign CMD_READY = (r_state == IDLE);
    assign BUSY      = (r_state != IDLE);
    assign TX_OUT    = r_tx;
    assign DONE      = r_done;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, accept and completion strobes.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (CMD_VALID) begin
                    w_next   = START;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_next = DATA;
                end else begin
                    w_next = START;
                end
            end
            DATA: begin
                if (w_bit_end && (r_bit_cnt == LAST_BIT)) begin
                    w_next = r_par_en ? PARITY : STOP;
                end else begin
                    w_next = DATA;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_next = STOP;
                end else begin
                    w_next = PARITY;
                end
            end
            STOP: begin
                if (w_bit_end && w_last_byte) begin
                    w_next = IDLE;
                    w_done = 1'b1;
                end else if (w_bit_end) begin
`ifdef HOST_FRAME_TX_GAP_EN
                    w_next = GAP;
`else
                    w_next = START;
`endif
                end else begin
                    w_next = STOP;
                end
            end
`ifdef HOST_FRAME_TX_GAP_EN
            GAP: begin
                if (w_bit_end) begin
                    w_next = START;
                end else begin
                    w_next = GAP;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Line level for the coming cycle, so TX_OUT is a register that tracks
    // the state register with no extra cycle of latency.
    always_comb begin
        w_nbit = {BCW{1'b0}};
        w_tx   = 1'b1;
        if ((r_state == DATA) && w_bit_end) begin
            w_nbit = r_bit_cnt + BCW'(1);
        end else if (r_state == DATA) begin
            w_nbit = r_bit_cnt;
        end else begin
            w_nbit = {BCW{1'b0}};
        end
        case (w_next)
            START:   w_tx = 1'b0;
            DATA:    w_tx = w_cur_byte[w_nbit];
            PARITY:  w_tx = w_par;
            default: w_tx = 1'b1;
        endcase
    end

    // Command capture, bit/byte/baud counters and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_type     <= 2'd0;
            r_arg0     <= {DATA_WIDTH{1'b0}};
            r_arg1     <= {DATA_WIDTH{1'b0}};
            r_arg2     <= {DATA_WIDTH{1'b0}};
            r_baud     <= 16'd0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= {BCW{1'b0}};
            r_byte_idx <= 2'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_done <= w_done;

            if (w_accept) begin
                r_type    <= CMD_TYPE;
                r_arg0    <= ARG0;
                r_arg1    <= ARG1;
                r_arg2    <= ARG2;
                r_baud    <= BAUD_DIV;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
            end else begin
                r_type    <= r_type;
                r_arg0    <= r_arg0;
                r_arg1    <= r_arg1;
                r_arg2    <= r_arg2;
                r_baud    <= r_baud;
                r_par_en  <= r_par_en;
                r_par_typ <= r_par_typ;
            end

            if ((r_state == IDLE) || w_bit_end) begin
                r_baud_cnt <= 16'd0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 16'd1;
            end

            if ((r_state == DATA) && w_bit_end) begin
                r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? {BCW{1'b0}} : (r_bit_cnt + BCW'(1));
            end else if (r_state != DATA) begin
                r_bit_cnt <= {BCW{1'b0}};
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end

            // Advances only between frames of the same command; the final
            // stop bit leaves it in place so it never wraps.
            if (w_accept) begin
                r_byte_idx <= 2'd0;
            end else if ((r_state == STOP) && w_bit_end && !w_last_byte) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end else begin
                r_byte_idx <= r_byte_idx;
            end
        end
    end

endmodule

// File: tb/tb_host_frame_tx.sv
module tb_host_frame_tx;

`ifdef HOST_FRAME_TX_GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE = 2'd0;
    logic [7:0]  ARG0 = 8'd0;
    logic [7:0]  ARG1 = 8'd0;
    logic [7:0]  ARG2 = 8'd0;
    logic [15:0] BAUD_DIV = 16'd0;
    logic        PAR_EN = 1'b0;
    logic        PAR_TYP = 1'b0;
    logic        TX_OUT;
    logic        BUSY;
    logic        DONE;

    host_frame_tx #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .ARG0(ARG0), .ARG1(ARG1), .ARG2(ARG2),
        .BAUD_DIV(BAUD_DIV), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .TX_OUT(TX_OUT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic       p;
    } exp_t;

    exp_t q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   frames_seen = 0;
    int   cur_baud = 1;
    bit   cur_pe = 1'b0;
    bit   frame_abort = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        q.push_back(e);
    endtask

    // Serial receiver: decodes each frame and compares it with the queue head.
    initial begin : monitor
        logic       prev_tx;
        logic [7:0] gd;
        logic       gp;
        logic       gs;
        int         div;
        bit         pe;
        exp_t       e;
        prev_tx = 1'b1;
        forever begin
            @(negedge CLK);
            if (RST && prev_tx && !TX_OUT) begin
                div = cur_baud;
                pe  = cur_pe;
                gp  = 1'b0;
                repeat (div) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    gd[i] = TX_OUT;
                    repeat (div) @(negedge CLK);
                end
                if (pe) begin
                    gp = TX_OUT;
                    repeat (div) @(negedge CLK);
                end
                gs = TX_OUT;
                if (frame_abort) begin
                    frame_abort = 1'b0;
                end else begin
                    check("frame_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        frames_seen++;
                        check("frame_data", {24'd0, gd}, {24'd0, e.d});
                        check("frame_stop", {31'd0, gs}, 32'd1);
                        if (pe) check("frame_parity", {31'd0, gp}, {31'd0, e.p});
                    end
                end
            end
            prev_tx = TX_OUT;
        end
    end

    // Counts busy cycles up to the DONE cycle; returns at the DONE negedge.
    task automatic wait_done(input string nm, input int exp_busy);
        int b;
        int n;
        b = 0;
        n = 0;
        @(negedge CLK);
        while (!DONE && n < 5000) begin
            if (BUSY) b++;
            n++;
            @(negedge CLK);
        end
        check({nm, "_busy_cycles"}, b, exp_busy);
        check({nm, "_done"}, {31'd0, DONE}, 32'd1);
        check({nm, "_ready_at_done"}, {31'd0, CMD_READY}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [15:0] bd, input logic pe,
                         input logic pt, input string nm);
        int n;
        n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check({nm, "_ready"}, {31'd0, CMD_READY}, 32'd1);
        cur_baud = (bd == 16'd0) ? 1 : int'(bd);
        cur_pe   = pe;
        CMD_TYPE = t; ARG0 = a0; ARG1 = a1; ARG2 = a2;
        BAUD_DIV = bd; PAR_EN = pe; PAR_TYP = pt;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0;
        CMD_TYPE = ~t; ARG0 = 8'hFF; ARG1 = 8'h00; ARG2 = 8'h5A;
        BAUD_DIV = 16'd7; PAR_EN = ~pe; PAR_TYP = ~pt;
        check({nm, "_start_bit"}, {31'd0, TX_OUT}, 32'd0);
        check({nm, "_busy_after_accept"}, {31'd0, BUSY}, 32'd1);
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input logic [15:0] bd, input logic pe,
                           input logic pt, input int exp_busy, input string nm);
        issue(t, a0, a1, a2, bd, pe, pt, nm);
        wait_done(nm, exp_busy);
        @(negedge CLK);
        check({nm, "_done_pulse"}, {31'd0, DONE}, 32'd0);
    endtask

    initial begin : stim
        int seen_done;
        repeat (3) @(negedge CLK);
        check("rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("rst_ready", {31'd0, CMD_READY}, 32'd1);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        RST = 1'b1;

        // RF write, 4 cycles/bit, no parity
        push_exp(8'hAA, 1'b0); push_exp(8'h05, 1'b0); push_exp(8'h3C, 1'b0);
        run_cmd(2'd0, 8'h05, 8'h3C, 8'h00, 16'd4, 1'b0, 1'b0, 120 + 8 * G, "aa_b4");

        // RF read with even then odd parity, 11-bit frames
        push_exp(8'hBB, 1'b0); push_exp(8'h0A, 1'b0);
        run_cmd(2'd1, 8'h0A, 8'h00, 8'h00, 16'd1, 1'b1, 1'b0, 22 + G, "bb_even");
        push_exp(8'hBB, 1'b1); push_exp(8'h0A, 1'b1);
        run_cmd(2'd1, 8'h0A, 8'h00, 8'h00, 16'd1, 1'b1, 1'b1, 22 + G, "bb_odd");

        // ALU with operands, BAUD_DIV=0 behaves as 1
        push_exp(8'hCC, 1'b0); push_exp(8'h10, 1'b0); push_exp(8'h20, 1'b0); push_exp(8'h01, 1'b0);
        run_cmd(2'd2, 8'h10, 8'h20, 8'h01, 16'd0, 1'b0, 1'b0, 40 + 3 * G, "cc_b0");

        // CMD_VALID held high: one command, then a second one in the DONE cycle
        push_exp(8'hDD, 1'b0); push_exp(8'h42, 1'b0);
        push_exp(8'hDD, 1'b0); push_exp(8'h42, 1'b0);
        @(negedge CLK);
        cur_baud = 1; cur_pe = 1'b0;
        CMD_TYPE = 2'd3; ARG0 = 8'h42; BAUD_DIV = 16'd1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1;
        wait_done("dd_hold1", 20 + G);
        @(posedge CLK);
        #1;
        check("dd_hold_restart_busy", {31'd0, BUSY}, 32'd1);
        check("dd_hold_restart_tx", {31'd0, TX_OUT}, 32'd0);
        CMD_VALID = 1'b0;
        wait_done("dd_hold2", 20 + G);

        // ALU no operands, 2 cycles/bit
        push_exp(8'hDD, 1'b0); push_exp(8'h0F, 1'b0);
        run_cmd(2'd3, 8'h0F, 8'h00, 8'h00, 16'd2, 1'b0, 1'b0, 40 + 2 * G, "dd_b2");

        // Reset during DATA bit 3 of the second byte (0x05, bit 3 = 0)
        push_exp(8'hAA, 1'b0);
        issue(2'd0, 8'h05, 8'h3C, 8'h00, 16'd2, 1'b0, 1'b0, "rst_mid");
        repeat (29 + 2 * G) @(posedge CLK);
        #1;
        check("rst_mid_bit3", {31'd0, TX_OUT}, 32'd0);
        frame_abort = 1'b1;
        RST = 1'b0;
        #1;
        check("rst_mid_tx_async", {31'd0, TX_OUT}, 32'd1);
        check("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        check("rst_mid_ready", {31'd0, CMD_READY}, 32'd1);
        seen_done = 0;
        repeat (3) begin
            @(negedge CLK);
            if (DONE) seen_done++;
        end
        RST = 1'b1;
        repeat (40) begin
            @(negedge CLK);
            if (DONE) seen_done++;
        end
        check("rst_mid_no_done", seen_done, 0);

        // Fresh command after reset, odd parity, 3 cycles/bit
        push_exp(8'hAA, 1'b1); push_exp(8'h05, 1'b1); push_exp(8'h3C, 1'b1);
        run_cmd(2'd0, 8'h05, 8'h3C, 8'h00, 16'd3, 1'b1, 1'b1, 99 + 6 * G, "aa_after_rst");

        repeat (20) @(negedge CLK);
        check("queue_empty", q.size(), 0);
        check("frames_seen", frames_seen, 21);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
